// File: rtl/gfx_cmd_pkg.sv
// Shared types for the SPI command controller: opcodes, FSM states and
// the payload width helper.
package gfx_cmd_pkg;

    typedef enum logic [7:0] {
        OP_NOP       = 8'h00,
        OP_WRITE     = 8'h01,
        OP_SET_SCORE = 8'h02,
        OP_SET_STATE = 8'h03,
        OP_CLEAR     = 8'h04,
        OP_SCORE_INC = 8'h05
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        PAYLOAD,
        EXEC,
        CLEAR,
        DRAIN
    } state_t;

    // Payload register width for a given payload byte count.
    function automatic int payload_w(input int bytes);
        return 8 * bytes;
    endfunction

endpackage

// File: rtl/gfx_payload_asm.sv
// Payload assembler: big-endian byte shift register plus received-byte count.
import gfx_cmd_pkg::*;

module gfx_payload_asm #(
    parameter int PAYLOAD_BYTES = 2,
    parameter int PW            = payload_w(PAYLOAD_BYTES),
    parameter int CNT_W         = $clog2(PAYLOAD_BYTES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift,
    input  logic [7:0]       byte_in,
    output logic [CNT_W-1:0] count,
    output logic [PW-1:0]    payload
);

    // New bytes enter at the bottom so the first byte ends up most significant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            payload <= '0;
        end else if (clr) begin
            count   <= '0;
            payload <= '0;
        end else if (shift) begin
            count   <= count + CNT_W'(1);
            payload <= PW'({payload, byte_in});
        end
    end

endmodule

// File: rtl/gfx_cmd_ctrl.sv
// SPI command controller: parses opcode/payload frames and drives tile-memory
// writes, the score register and the game-state register.
// Optional feature macro: GFX_CLEAR_EN enables the 0x04 memory-clear sweep;
// without it 0x04 decodes as an unknown opcode and busy is tied low.
import gfx_cmd_pkg::*;

module gfx_cmd_ctrl #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 3,
    parameter int SCORE_W       = 10,
    parameter int STATE_W       = 16,
    parameter int PAYLOAD_BYTES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               rx_valid,
    input  logic [7:0]         rx_byte,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [DATA_W-1:0]  wdata,
    output logic [SCORE_W-1:0] score,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               frame_err
);

    localparam int PW    = payload_w(PAYLOAD_BYTES);
    localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);

    state_t           state_q, state_d;
    logic             cs_d;
    logic [7:0]       opc_q;
    logic             opc_ld;
    logic             asm_clr, asm_shift;
    logic [CNT_W-1:0] count;
    logic [PW-1:0]    payload;
    logic [PW-1:0]    payload_nx;
    logic             byte_ok;
    logic             fire;
    logic [7:0]       fire_op;
    logic             err;
    logic             busy_q;
    logic             sweep_last;
    logic             unused_bits;

    gfx_payload_asm #(
        .PAYLOAD_BYTES(PAYLOAD_BYTES),
        .PW           (PW),
        .CNT_W        (CNT_W)
    ) u_asm (
        .clk    (clk),
        .reset  (reset),
        .clr    (asm_clr),
        .shift  (asm_shift),
        .byte_in(rx_byte),
        .count  (count),
        .payload(payload)
    );

    // Payload including the byte arriving this cycle, so a completing byte
    // executes on the same edge it is accepted.
    assign payload_nx  = PW'({payload, rx_byte});
    assign unused_bits = ^payload_nx;

    // A byte counts while cs is high or has only just fallen this cycle.
    assign byte_ok = rx_valid & (cs | cs_d);

    assign busy = busy_q;

`ifdef GFX_CLEAR_EN
    assign sweep_last = busy_q && (waddr == {ADDR_W{1'b1}});
`else
    assign sweep_last = 1'b0;
    assign busy_q     = 1'b0;
`endif

    // FSM state, cs edge history and latched opcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cs_d    <= 1'b0;
            opc_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cs_d    <= cs;
            if (opc_ld)
                opc_q <= rx_byte;
        end
    end

    // Next state, frame decode and error detection.
    always_comb begin
        state_d   = state_q;
        err       = 1'b0;
        fire      = 1'b0;
        fire_op   = opc_q;
        asm_clr   = 1'b0;
        asm_shift = 1'b0;
        opc_ld    = 1'b0;
        case (state_q)
            IDLE: begin
                asm_clr = 1'b1;
                if (cs && !cs_d)
                    state_d = OPCODE;
            end
            OPCODE: begin
                if (byte_ok) begin
                    opc_ld = 1'b1;
                    case (rx_byte)
                        OP_NOP, OP_SCORE_INC
`ifdef GFX_CLEAR_EN
                        , OP_CLEAR
`endif
                        : begin
                            fire    = 1'b1;
                            fire_op = rx_byte;
                            state_d = EXEC;
                        end
                        OP_WRITE, OP_SET_SCORE, OP_SET_STATE:
                            state_d = PAYLOAD;
                        default: begin
                            err     = 1'b1;
                            state_d = DRAIN;
                        end
                    endcase
                end else if (!cs) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (byte_ok) begin
                    asm_shift = 1'b1;
                    if (count == CNT_W'(PAYLOAD_BYTES - 1)) begin
                        fire    = 1'b1;
                        state_d = EXEC;
                    end
                end else if (!cs) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            EXEC: begin
`ifdef GFX_CLEAR_EN
                state_d = (opc_q == OP_CLEAR) ? CLEAR : DRAIN;
`else
                state_d = DRAIN;
`endif
            end
            CLEAR: begin
                if (sweep_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (!cs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Bytes arriving while the sweep owns the memory port are dropped.
        if (busy_q && rx_valid)
            err = 1'b1;
    end

    // Execution registers: memory write port, score, game state, sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            score     <= '0;
            state     <= '0;
            frame_err <= 1'b0;
`ifdef GFX_CLEAR_EN
            busy_q    <= 1'b0;
`endif
        end else begin
            frame_err <= err;
            we        <= 1'b0;
`ifdef GFX_CLEAR_EN
            if (busy_q) begin
                if (sweep_last) begin
                    busy_q <= 1'b0;
                end else begin
                    we    <= 1'b1;
                    waddr <= waddr + ADDR_W'(1);
                end
            end
`endif
            if (fire) begin
                case (fire_op)
                    OP_WRITE: begin
                        we    <= 1'b1;
                        waddr <= payload_nx[ADDR_W+DATA_W-1:DATA_W];
                        wdata <= payload_nx[DATA_W-1:0];
                    end
                    OP_SET_SCORE: score <= payload_nx[SCORE_W-1:0];
                    OP_SET_STATE: state <= payload_nx[STATE_W-1:0];
                    OP_SCORE_INC: begin
                        if (score != {SCORE_W{1'b1}})
                            score <= score + SCORE_W'(1);
                    end
`ifdef GFX_CLEAR_EN
                    OP_CLEAR: begin
                        busy_q <= 1'b1;
                        we     <= 1'b1;
                        waddr  <= '0;
                        wdata  <= '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
